// File: rtl/cache_arbiter.sv
// Two-port cache arbiter: shares one cacheline adapter between icache and dcache,
// one transaction outstanding, round-robin on simultaneous requests.
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_read,
  output logic                  m_write,
  output logic [LINE_WIDTH-1:0] m_wdata,
  input  logic [LINE_WIDTH-1:0] m_rdata,
  input  logic                  m_resp
);

  typedef enum logic [1:0] {ARB_IDLE, SERVE_I, SERVE_D} state_e;
  typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_e;

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic                  m_read_q, m_read_d;
  logic                  m_write_q, m_write_d;
  logic [LINE_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic                  d_req;
  logic                  pick_d;

  // Next-state: grant in idle, hold request payload while serving, release on m_resp
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_addr_d     = m_addr_q;
    m_read_d     = m_read_q;
    m_write_d    = m_write_q;
    m_wdata_d    = m_wdata_q;
    d_req        = d_read | d_write;
    pick_d       = d_req & (~i_read | (last_grant_q == GRANT_I));
    case (state_q)
      ARB_IDLE: begin
        if (pick_d) begin
          // Both read and write high is treated as a writeback.
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          m_addr_d     = d_addr;
          m_write_d    = d_write;
          m_read_d     = ~d_write;
          m_wdata_d    = d_wdata;
        end else if (i_read) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          m_addr_d     = i_addr;
          m_read_d     = 1'b1;
          m_write_d    = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (m_resp) begin
          state_d   = ARB_IDLE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_I;
      m_addr_q     <= '0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      m_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_addr_q     <= m_addr_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
      m_wdata_q    <= m_wdata_d;
    end
  end

  // Completion is forwarded in the same cycle the adapter responds
  assign i_resp  = (state_q == SERVE_I) & m_resp;
  assign d_resp  = (state_q == SERVE_D) & m_resp;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign m_addr  = m_addr_q;
  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a simple adapter/requester environment,
// a transaction-level reference model checked every cycle, plus literal checks.
module tb_cache_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk, rst;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic          i_read, i_resp, d_read, d_write, d_resp;
  logic          m_read, m_write, m_resp;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_resp(m_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the adapter, whose turn a tie is, and the latched request
  int            own;      // 0 none, 1 icache, 2 dcache
  int            last_own; // 1 icache, 2 dcache
  bit            e_rd, e_wr;
  bit [AW-1:0]   e_addr;
  bit [LW-1:0]   e_wdata;

  always @(negedge clk) begin
    if (rst) begin
      own = 0; last_own = 1; e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
    end
    chk("m_read", LW'(m_read), LW'(e_rd));
    chk("m_write", LW'(m_write), LW'(e_wr));
    chk("i_resp", LW'(i_resp), LW'(own == 1 && m_resp));
    chk("d_resp", LW'(d_resp), LW'(own == 2 && m_resp));
    if (own != 0 || rst) chk("m_addr", LW'(m_addr), LW'(e_addr));
    if (e_wr || rst) chk("m_wdata", m_wdata, e_wdata);
    if (own == 1 && m_resp) chk("i_rdata", i_rdata, m_rdata);
    if (own == 2 && m_resp) chk("d_rdata", d_rdata, m_rdata);
    if (!rst) begin
      if (own == 0) begin
        if ((d_read || d_write) && (!i_read || last_own == 1)) begin
          own = 2; last_own = 2; e_addr = d_addr; e_wr = d_write; e_rd = !d_write;
          e_wdata = d_wdata;
        end else if (i_read) begin
          own = 1; last_own = 1; e_addr = i_addr; e_rd = 1; e_wr = 0;
        end
      end else if (m_resp) begin
        own = 0; e_rd = 0; e_wr = 0;
      end
    end
  end

  // Environment: adapter answers after lat cycles; requesters drop the cycle after resp
  int            lat = 4;
  int            cnt = 0;
  bit            auto_mem = 1;
  logic [LW-1:0] mem_data;

  task automatic step();
    logic ir, dr;
    ir = i_resp;
    dr = d_resp;
    @(posedge clk);
    #1;
    if (ir) i_read = 1'b0;
    if (dr) begin d_read = 1'b0; d_write = 1'b0; end
    if (auto_mem) begin
      if (m_resp) begin
        m_resp = 1'b0;
        cnt = 0;
      end else if (m_read || m_write) begin
        cnt++;
        if (cnt == lat) begin m_resp = 1'b1; m_rdata = mem_data; end
      end
    end
    #1;
  endtask

  task automatic run_until_resp(output int who, output int n);
    who = 0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (i_resp) begin who = 1; n = k; break; end
      if (d_resp) begin who = 2; n = k; break; end
    end
    if (who == 0) chk("resp_timeout", LW'(0), LW'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1; cnt = 0; m_resp = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  logic [LW-1:0] pat_a, pat_b;
  int who, n;

  initial begin
    rst = 1'b1; i_addr = '0; i_read = 0; d_addr = '0; d_read = 0; d_write = 0;
    d_wdata = '0; m_rdata = '0; m_resp = 0;
    pat_a = {8{32'hA5A5_0001}};
    pat_b = {8{32'h5A5A_0B0B}};
    mem_data = pat_a;
    step(); step();
    chk("rst_m_read", LW'(m_read), LW'(0));
    chk("rst_m_write", LW'(m_write), LW'(0));
    chk("rst_m_addr", LW'(m_addr), LW'(0));
    chk("rst_m_wdata", m_wdata, LW'(0));
    rst = 1'b0;

    // Icache alone
    i_addr = 32'h0000_1040; i_read = 1; mem_data = pat_a;
    step();
    chk("ic_m_read", LW'(m_read), LW'(1));
    chk("ic_m_addr", LW'(m_addr), LW'(32'h0000_1040));
    run_until_resp(who, n);
    chk("ic_who", LW'(who), LW'(1));
    chk("ic_latency", LW'(n), LW'(3));
    chk("ic_rdata", i_rdata, pat_a);
    chk("ic_no_dresp", LW'(d_resp), LW'(0));
    step();
    chk("ic_m_read_clr", LW'(m_read), LW'(0));

    // Dcache writeback
    d_addr = 32'h8000_0020; d_write = 1; d_wdata = pat_b; mem_data = pat_a;
    step();
    chk("dw_m_write", LW'(m_write), LW'(1));
    chk("dw_m_read", LW'(m_read), LW'(0));
    chk("dw_m_wdata", m_wdata, pat_b);
    chk("dw_m_addr", LW'(m_addr), LW'(32'h8000_0020));
    run_until_resp(who, n);
    chk("dw_who", LW'(who), LW'(2));
    chk("dw_no_iresp", LW'(i_resp), LW'(0));
    step();

    // Ties after reset alternate D then I over 8 rounds
    do_reset();
    for (int r = 0; r < 8; r++) begin
      i_addr = AW'(32'h0000_2000 + r * 64);
      d_addr = AW'(32'h0000_9000 + r * 64);
      mem_data = {8{AW'(32'hC0DE_0000 + r)}};
      i_read = 1; d_read = 1;
      run_until_resp(who, n);
      chk("rr_first", LW'(who), LW'(2));
      step();
      run_until_resp(who, n);
      chk("rr_second", LW'(who), LW'(1));
      step();
    end

    // Read and write both high is a writeback; inputs changed mid-service are ignored
    d_addr = 32'h0000_3300; d_read = 1; d_write = 1; d_wdata = pat_a; lat = 5;
    step();
    chk("both_m_write", LW'(m_write), LW'(1));
    d_addr = 32'h0000_7700; d_wdata = pat_b;
    step(); step();
    chk("hold_m_addr", LW'(m_addr), LW'(32'h0000_3300));
    chk("hold_m_wdata", m_wdata, pat_a);
    run_until_resp(who, n);
    chk("hold_who", LW'(who), LW'(2));
    step();

    // Reset two cycles into an icache read aborts it; request is re-granted after release
    lat = 10; i_addr = 32'h0000_4400; i_read = 1;
    step(); step(); step();
    rst = 1'b1; cnt = 0;
    #1;
    chk("abort_m_read", LW'(m_read), LW'(0));
    chk("abort_i_resp", LW'(i_resp), LW'(0));
    step();
    chk("abort_hold_i_resp", LW'(i_resp), LW'(0));
    rst = 1'b0; lat = 4;
    step();
    chk("regrant_m_read", LW'(m_read), LW'(1));
    chk("regrant_m_addr", LW'(m_addr), LW'(32'h0000_4400));
    run_until_resp(who, n);
    chk("regrant_who", LW'(who), LW'(1));
    step();

    // Spurious adapter response while idle
    auto_mem = 0; m_resp = 1; m_rdata = pat_b;
    #1;
    chk("spur_i_resp", LW'(i_resp), LW'(0));
    chk("spur_d_resp", LW'(d_resp), LW'(0));
    step();
    m_resp = 0; auto_mem = 1; cnt = 0;
    chk("spur_m_read", LW'(m_read), LW'(0));
    i_addr = 32'h0000_5500; i_read = 1;
    step();
    chk("spur_idle_grant", LW'(m_read), LW'(1));
    run_until_resp(who, n);
    chk("spur_after_who", LW'(who), LW'(1));
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
